spdif_channel_status_sequencer: RTL and testbench
=================================================

Name: spdif_channel_status_sequencer

Overview:
Sequences the 192-bit consumer (mode 0) channel status block onto the S/PDIF frame stream, one status bit per subframe, frame index n carrying word bit n. Holds the active status configuration and double-buffers updates so a new configuration takes effect only on a block boundary. Sits between the audio sample scheduler and the subframe encoder: it offers per-frame C bits for left and right plus a block-start flag through a valid/ready handshake.

Parameters:
COPYRIGHT_FREE, 1, value of word bit 2 (1 = copyright not asserted)
CLOCK_ACCURACY, 2'b00, value of word bits 29:28 (00 = Level II)
NON_AUDIO, 0, value of word bit 1 (0 = linear PCM)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  1 = run the sequencer; 0 = idle and rewind
cfgLoad  in  1  one-cycle pulse; capture cfg* inputs as pending configuration
cfgCategory  in  8  category code, word bits 15:8
cfgSamplingFreq  in  4  word bits 27:24
cfgWordLength  in  4  word bits 35:32
cfgChanLeft  in  4  channel number for left subframes, word bits 23:20
cfgChanRight  in  4  channel number for right subframes, word bits 23:20
csReady  in  1  encoder consumes current frame's status bits
csValid  out  1  csLeft/csRight/blockStart valid
csLeft  out  1  C bit for left subframe of current frame
csRight  out  1  C bit for right subframe of current frame
blockStart  out  1  current frame is frame 0 (encoder emits B preamble)
frameIndex  out  8  current frame index 0..191
cfgPending  out  1  a loaded configuration awaits the next block boundary

Behaviour:
- Word layout per channel: b0=0, b1=NON_AUDIO, b2=COPYRIGHT_FREE, b5:3=0, b7:6=0, b15:8=category, b19:16=0 (source number), b23:20=channel number (left/right value respectively), b27:24=samplingFreq, b29:28=CLOCK_ACCURACY, b31:30=0, b35:32=wordLength, b39:36=0, b191:40=0. Left and right words differ only in b23:20.
- Reset (synchronous, overrides everything): frameIndex=0, csValid=0, csLeft=0, csRight=0, blockStart=0, cfgPending=0; active and shadow configuration registers capture the cfg* inputs.
- States: IDLE, RUN.
- IDLE: csValid=0, frameIndex=0. enable=1 -> RUN; on the next cycle csValid=1, frameIndex=0, blockStart=1, csLeft/csRight = bit 0 of each word. 1-cycle latency from enable to csValid.
- RUN, handshake = csValid & csReady: frameIndex advances by 1, wrapping 191 -> 0; outputs for the new index are registered on the same edge, so csValid stays 1 with no bubble. No handshake: all outputs hold.
- blockStart = (frameIndex == 0), registered together with the bits.
- cfgLoad: shadow <= cfg* inputs, cfgPending <= 1; a second cfgLoad before the boundary overwrites the shadow.
- Block boundary = handshake at frameIndex==191: if cfgPending, active <= shadow and cfgPending <= 0; the frame-0 bits use the new active config. A cfgLoad on the boundary cycle bypasses the shadow: its inputs go straight to active and cfgPending stays 0.
- In IDLE, cfgLoad writes active directly; cfgPending remains 0.
- enable falling in RUN, including mid-block: next cycle -> IDLE, csValid=0, frameIndex=0, and any pending shadow is copied to active (cfgPending=0). A handshake on that same cycle is discarded.
- Bit selection uses a combinational 192:1 mux on the next index; the active word is never stored as a 192-bit register (only config fields are).

Decomposition:
- Package spdif_cs_pkg: CS_BLOCK_FRAMES=192, CS_LAST_FRAME=191, field LSB/width constants (category 8/8, channel 20/4, fs 24/4, clock accuracy 28/2, word length 32/4), and a packed struct of the config fields.
- One sub-module, spdif_cs_bit_select: combinational mux taking the config struct, channel number and index and returning one status bit. Instantiated twice (left, right).

Test Plan:
- Reset, enable=1, cfgCategory=8'h99, fs=4'd2, wl=4'd2, chanL=1, chanR=2, csReady=1 for 192 cycles -> 192 frames. Left word reassembles to b2=1, b15:8=8'h99, b23:20=1, b27:24=2, b35:32=2, all other bits 0. Right word is identical except b23:20=2. blockStart is high only at index 0.
- csReady toggling 1/0 pseudo-randomly -> index advances only on handshakes and outputs hold while csReady=0. After 384 handshakes, exactly 2 blockStart frames.
- cfgLoad with category=8'h02 at index 50 -> cfgPending=1 through index 191. Frame 0 of the next block carries category 8'h02 and cfgPending clears; indices 50..191 still carry 8'h99.
- cfgLoad on the index-191 handshake cycle with category=8'h10 -> next block uses 8'h10 and cfgPending never asserts.
- enable dropped at index 100 with a pending config -> csValid=0 and frameIndex=0 next cycle. Re-enable -> blockStart=1, index 0, new config active.
- reset asserted at index 120 while running -> all outputs 0 next cycle. Recovers at index 0 with the cfg* values present during reset.

Source files
------------

// File: rtl/spdif_cs_pkg.sv
// Shared types and constants for the S/PDIF consumer channel status sequencer.
// Holds block geometry, field positions inside the 192-bit status word and the config bundle.
package spdif_cs_pkg;

    localparam int CS_BLOCK_FRAMES = 192;
    localparam int CS_LAST_FRAME   = CS_BLOCK_FRAMES - 1;

    localparam int CS_CAT_LSB    = 8;
    localparam int CS_CAT_W      = 8;
    localparam int CS_CHAN_LSB   = 20;
    localparam int CS_CHAN_W     = 4;
    localparam int CS_FS_LSB     = 24;
    localparam int CS_FS_W       = 4;
    localparam int CS_CLKACC_LSB = 28;
    localparam int CS_CLKACC_W   = 2;
    localparam int CS_WL_LSB     = 32;
    localparam int CS_WL_W       = 4;

    typedef struct packed {
        logic [7:0] category;
        logic [3:0] samplingFreq;
        logic [3:0] wordLength;
        logic [3:0] chanLeft;
        logic [3:0] chanRight;
    } cs_cfg_t;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } cs_state_t;

endpackage

// File: rtl/spdif_cs_bit_select.sv
// Combinational selector of one channel status bit for a given frame index.
// Ports: i_cfg config fields, i_chan channel number, i_index frame index, o_bit status bit.
module spdif_cs_bit_select
    import spdif_cs_pkg::*;
#(
    parameter logic       COPYRIGHT_FREE = 1'b1,
    parameter logic [1:0] CLOCK_ACCURACY = 2'b00,
    parameter logic       NON_AUDIO      = 1'b0
) (
    input  cs_cfg_t    i_cfg,
    input  logic [3:0] i_chan,
    input  logic [7:0] i_index,
    output logic       o_bit
);

    // Only the low 40 bits carry fields; everything above is zero.
    logic [63:0] w_word;
    logic        w_unused_chan;

    // Per-channel numbers arrive separately through i_chan.
    assign w_unused_chan = ^{i_cfg.chanLeft, i_cfg.chanRight};

    always_comb begin
        w_word = '0;
        w_word[1] = NON_AUDIO;
        w_word[2] = COPYRIGHT_FREE;
        w_word[CS_CAT_LSB +: CS_CAT_W] = i_cfg.category;
        w_word[CS_CHAN_LSB +: CS_CHAN_W] = i_chan;
        w_word[CS_FS_LSB +: CS_FS_W] = i_cfg.samplingFreq;
        w_word[CS_CLKACC_LSB +: CS_CLKACC_W] = CLOCK_ACCURACY;
        w_word[CS_WL_LSB +: CS_WL_W] = i_cfg.wordLength;
    end

    assign o_bit = (i_index[7:6] == 2'b00) ? w_word[i_index[5:0]] : 1'b0;

endmodule

// File: rtl/spdif_channel_status_sequencer.sv
// Emits per-frame C bits of the consumer channel status block with a valid/ready handshake.
// Ports: clock/reset, enable, cfgLoad + cfg* fields in; csValid/csLeft/csRight/blockStart/frameIndex/cfgPending out.
module spdif_channel_status_sequencer
    import spdif_cs_pkg::*;
#(
    parameter logic       COPYRIGHT_FREE = 1'b1,
    parameter logic [1:0] CLOCK_ACCURACY = 2'b00,
    parameter logic       NON_AUDIO      = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       cfgLoad,
    input  logic [7:0] cfgCategory,
    input  logic [3:0] cfgSamplingFreq,
    input  logic [3:0] cfgWordLength,
    input  logic [3:0] cfgChanLeft,
    input  logic [3:0] cfgChanRight,
    input  logic       csReady,
    output logic       csValid,
    output logic       csLeft,
    output logic       csRight,
    output logic       blockStart,
    output logic [7:0] frameIndex,
    output logic       cfgPending
);

    localparam logic [7:0] LAST_IDX = 8'(CS_LAST_FRAME);

    cs_state_t  r_state;
    logic [7:0] r_idx;
    cs_cfg_t    r_active;
    cs_cfg_t    r_shadow;
    logic       r_pending;
    logic       r_valid;
    logic       r_left;
    logic       r_right;
    logic       r_bs;

    cs_cfg_t    w_cfg_in;
    cs_cfg_t    w_cfg_nxt;
    logic [7:0] w_idx_nxt;
    logic       w_hs;
    logic       w_boundary;
    logic       w_bit_l;
    logic       w_bit_r;

    assign w_cfg_in = '{
        category:     cfgCategory,
        samplingFreq: cfgSamplingFreq,
        wordLength:   cfgWordLength,
        chanLeft:     cfgChanLeft,
        chanRight:    cfgChanRight
    };

    assign w_hs       = (r_state == ST_RUN) & r_valid & csReady;
    assign w_boundary = w_hs & (r_idx == LAST_IDX);

    // Config and index that the next registered frame will use.
    always_comb begin
        w_cfg_nxt = r_active;
        w_idx_nxt = r_idx;
        case (r_state)
            ST_IDLE: begin
                w_idx_nxt = '0;
                if (cfgLoad) w_cfg_nxt = w_cfg_in;
            end
            ST_RUN: begin
                if (!enable || w_boundary) begin
                    w_idx_nxt = '0;
                    if (cfgLoad)        w_cfg_nxt = w_cfg_in;
                    else if (r_pending) w_cfg_nxt = r_shadow;
                end else if (w_hs) begin
                    w_idx_nxt = r_idx + 8'd1;
                end
            end
            default: ;
        endcase
    end

    spdif_cs_bit_select #(
        .COPYRIGHT_FREE(COPYRIGHT_FREE),
        .CLOCK_ACCURACY(CLOCK_ACCURACY),
        .NON_AUDIO     (NON_AUDIO)
    ) u_sel_l (
        .i_cfg  (w_cfg_nxt),
        .i_chan (w_cfg_nxt.chanLeft),
        .i_index(w_idx_nxt),
        .o_bit  (w_bit_l)
    );

    spdif_cs_bit_select #(
        .COPYRIGHT_FREE(COPYRIGHT_FREE),
        .CLOCK_ACCURACY(CLOCK_ACCURACY),
        .NON_AUDIO     (NON_AUDIO)
    ) u_sel_r (
        .i_cfg  (w_cfg_nxt),
        .i_chan (w_cfg_nxt.chanRight),
        .i_index(w_idx_nxt),
        .o_bit  (w_bit_r)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_active  <= w_cfg_in;
            r_shadow  <= w_cfg_in;
            r_pending <= 1'b0;
            r_valid   <= 1'b0;
            r_left    <= 1'b0;
            r_right   <= 1'b0;
            r_bs      <= 1'b0;
        end else begin
            r_active <= w_cfg_nxt;
            case (r_state)
                ST_IDLE: begin
                    r_idx     <= '0;
                    r_pending <= 1'b0;
                    if (enable) begin
                        r_state <= ST_RUN;
                        r_valid <= 1'b1;
                        r_left  <= w_bit_l;
                        r_right <= w_bit_r;
                        r_bs    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        // Leaving mid-block: drop the frame and fold any pending config in.
                        r_state   <= ST_IDLE;
                        r_idx     <= '0;
                        r_pending <= 1'b0;
                        r_valid   <= 1'b0;
                        r_left    <= 1'b0;
                        r_right   <= 1'b0;
                        r_bs      <= 1'b0;
                    end else begin
                        if (w_hs) begin
                            r_idx   <= w_idx_nxt;
                            r_left  <= w_bit_l;
                            r_right <= w_bit_r;
                            r_bs    <= (w_idx_nxt == 8'd0);
                        end
                        // A load on the boundary went straight to active.
                        if (w_boundary) begin
                            r_pending <= 1'b0;
                        end else if (cfgLoad) begin
                            r_shadow  <= w_cfg_in;
                            r_pending <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign csValid    = r_valid;
    assign csLeft     = r_left;
    assign csRight    = r_right;
    assign blockStart = r_bs;
    assign frameIndex = r_idx;
    assign cfgPending = r_pending;

endmodule

// File: tb/tb_spdif_channel_status_sequencer.sv
// Self-checking bench for the channel status sequencer.
// Compares DUT frames against a word-level model of the status block.
module tb_spdif_channel_status_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       cfgLoad;
    logic [7:0] cfgCategory;
    logic [3:0] cfgSamplingFreq;
    logic [3:0] cfgWordLength;
    logic [3:0] cfgChanLeft;
    logic [3:0] cfgChanRight;
    logic       csReady;
    logic       csValid;
    logic       csLeft;
    logic       csRight;
    logic       blockStart;
    logic [7:0] frameIndex;
    logic       cfgPending;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] cat;
        logic [3:0] fs;
        logic [3:0] wl;
        logic [3:0] cl;
        logic [3:0] cr;
    } mcfg_t;

    mcfg_t m_act;
    mcfg_t m_sh;
    bit    m_pend;
    int    m_idx;

    always #5 clock = ~clock;

    spdif_channel_status_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .cfgLoad        (cfgLoad),
        .cfgCategory    (cfgCategory),
        .cfgSamplingFreq(cfgSamplingFreq),
        .cfgWordLength  (cfgWordLength),
        .cfgChanLeft    (cfgChanLeft),
        .cfgChanRight   (cfgChanRight),
        .csReady        (csReady),
        .csValid        (csValid),
        .csLeft         (csLeft),
        .csRight        (csRight),
        .blockStart     (blockStart),
        .frameIndex     (frameIndex),
        .cfgPending     (cfgPending)
    );

    // Status word bit n for one channel, from the consumer layout.
    function automatic bit exp_bit(input mcfg_t c, input logic [3:0] ch, input int n);
        if (n == 2) return 1'b1;
        if (n >= 8 && n <= 15) return c.cat[n-8];
        if (n >= 20 && n <= 23) return ch[n-20];
        if (n >= 24 && n <= 27) return c.fs[n-24];
        if (n >= 32 && n <= 35) return c.wl[n-32];
        return 1'b0;
    endfunction

    function automatic mcfg_t cur_in();
        mcfg_t c;
        c.cat = cfgCategory;
        c.fs  = cfgSamplingFreq;
        c.wl  = cfgWordLength;
        c.cl  = cfgChanLeft;
        c.cr  = cfgChanRight;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic frame_check();
        chk("valid", 192'(csValid), 192'(1));
        chk("index", 192'(frameIndex), 192'(m_idx));
        chk("left", 192'(csLeft), 192'(exp_bit(m_act, m_act.cl, m_idx)));
        chk("right", 192'(csRight), 192'(exp_bit(m_act, m_act.cr, m_idx)));
        chk("bstart", 192'(blockStart), 192'(m_idx == 0));
        chk("pending", 192'(cfgPending), 192'(m_pend));
    endtask

    // One handshake with csReady=1, optional cfgLoad, then model update.
    task automatic adv(input bit load);
        mcfg_t in;
        in = cur_in();
        cfgLoad = load;
        csReady = 1'b1;
        step();
        cfgLoad = 1'b0;
        if (m_idx == 191) begin
            if (load) m_act = in;
            else if (m_pend) m_act = m_sh;
            m_pend = 0;
            m_idx = 0;
        end else begin
            if (load) begin
                m_sh = in;
                m_pend = 1;
            end
            m_idx++;
        end
    endtask

    task automatic run_to(input int target);
        while (m_idx != target) begin
            frame_check();
            adv(1'b0);
        end
    endtask

    initial begin
        logic [191:0] lw, rw, elw, erw;
        int hs_cnt, bs_cnt, cyc;
        bit r;

        reset = 1'b1;
        enable = 1'b0;
        cfgLoad = 1'b0;
        csReady = 1'b0;
        cfgCategory = 8'h99;
        cfgSamplingFreq = 4'd2;
        cfgWordLength = 4'd2;
        cfgChanLeft = 4'd1;
        cfgChanRight = 4'd2;
        step();
        step();
        chk("rst_valid", 192'(csValid), 192'(0));
        chk("rst_index", 192'(frameIndex), 192'(0));
        chk("rst_bstart", 192'(blockStart), 192'(0));
        chk("rst_pending", 192'(cfgPending), 192'(0));
        chk("rst_bits", 192'({csLeft, csRight}), 192'(0));
        m_act = cur_in();
        m_sh = m_act;
        m_pend = 0;
        m_idx = 0;

        // Full block with csReady held high.
        reset = 1'b0;
        enable = 1'b1;
        step();
        for (int i = 0; i < 192; i++) begin
            frame_check();
            lw[i] = csLeft;
            rw[i] = csRight;
            adv(1'b0);
        end
        for (int n = 0; n < 192; n++) begin
            elw[n] = exp_bit(m_act, 4'd1, n);
            erw[n] = exp_bit(m_act, 4'd2, n);
        end
        chk("left_word", lw, elw);
        chk("right_word", rw, erw);
        chk("left_cat", 192'(lw[15:8]), 192'(8'h99));
        chk("right_chan", 192'(rw[23:20]), 192'(4'd2));

        // Random back-pressure: index only moves on handshakes.
        hs_cnt = 0;
        bs_cnt = 0;
        cyc = 0;
        while (hs_cnt < 384 && cyc < 5000) begin
            r = 1'($urandom_range(0, 1));
            csReady = r;
            frame_check();
            if (r && blockStart) bs_cnt++;
            step();
            cyc++;
            if (r) begin
                hs_cnt++;
                m_idx = (m_idx + 1) % 192;
            end
        end
        chk("rand_budget", 192'(hs_cnt), 192'(384));
        chk("rand_bstarts", 192'(bs_cnt), 192'(2));
        csReady = 1'b1;

        // Load at index 50; takes effect at the next block.
        run_to(50);
        frame_check();
        cfgCategory = 8'h02;
        adv(1'b1);
        chk("pend_set", 192'(cfgPending), 192'(1));
        run_to(0);
        frame_check();
        chk("new_cat", 192'(m_act.cat), 192'(8'h02));

        // Load on the boundary handshake bypasses the shadow.
        run_to(191);
        frame_check();
        cfgCategory = 8'h10;
        adv(1'b1);
        chk("bypass_pend", 192'(cfgPending), 192'(0));
        run_to(40);

        // Disable mid-block with a pending config.
        run_to(95);
        cfgCategory = 8'h33;
        adv(1'b1);
        run_to(100);
        frame_check();
        enable = 1'b0;
        step();
        m_act = m_sh;
        m_pend = 0;
        m_idx = 0;
        chk("dis_valid", 192'(csValid), 192'(0));
        chk("dis_index", 192'(frameIndex), 192'(0));
        chk("dis_pending", 192'(cfgPending), 192'(0));
        step();
        chk("idle_valid", 192'(csValid), 192'(0));
        enable = 1'b1;
        step();
        frame_check();
        run_to(40);

        // Reset while running at index 120.
        run_to(120);
        cfgCategory = 8'h5A;
        cfgSamplingFreq = 4'd3;
        cfgWordLength = 4'hB;
        cfgChanLeft = 4'd4;
        cfgChanRight = 4'd7;
        reset = 1'b1;
        step();
        chk("rr_valid", 192'(csValid), 192'(0));
        chk("rr_index", 192'(frameIndex), 192'(0));
        chk("rr_bits", 192'({csLeft, csRight, blockStart}), 192'(0));
        chk("rr_pending", 192'(cfgPending), 192'(0));
        m_act = cur_in();
        m_pend = 0;
        m_idx = 0;
        reset = 1'b0;
        step();
        run_to(191);
        frame_check();
        adv(1'b0);
        frame_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
